led_reg_sequencer: RTL

Register-access sequencer between the I2C slave byte engine and the LED controller's register-file bus. It turns an addressed I2C transaction into single-cycle register writes and reads. The first written byte is a control byte holding the register pointer and auto-increment mode; the pointer then advances per PCA9633 rules. It is the only master of the register bus, so bus enables are never driven elsewhere.

---
 rtl/led_reg_sequencer_if.sv | 14 +
 rtl/led_reg_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/led_reg_sequencer_if.sv
// rtl/led_reg_sequencer_if.sv - register-file bus between the sequencer (master) and the LED register file (slave)
interface led_reg_sequencer_if #(
  parameter int ADDR_BITS = 4,
  parameter int DATA_BITS = 8
);
  logic [ADDR_BITS-1:0] bus_addr;
  logic [DATA_BITS-1:0] bus_wdata;
  logic [DATA_BITS-1:0] bus_rdata;
  logic                 bus_w_en;
  logic                 bus_r_en;

  modport master (output bus_addr, bus_wdata, bus_w_en, bus_r_en, input bus_rdata);
  modport slave  (input bus_addr, bus_wdata, bus_w_en, bus_r_en, output bus_rdata);
endinterface

// File: rtl/led_reg_sequencer.sv
// rtl/led_reg_sequencer.sv - turns addressed I2C byte transfers into single-cycle register-bus writes and reads
// Control byte sets pointer and auto-increment mode; pointer then advances by PCA9633 rules.
module led_reg_sequencer #(
  parameter int ADDR_BITS = 4,
  parameter int DATA_BITS = 8,
  parameter int NUM_REGS  = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 xfer_start,
  input  logic                 xfer_rw,
  input  logic                 xfer_stop,
  input  logic                 wr_valid,
  input  logic [DATA_BITS-1:0] wr_byte,
  input  logic                 rd_req,
  output logic [DATA_BITS-1:0] rd_byte,
  output logic                 rd_valid,
  led_reg_sequencer_if.master  bus,
  output logic [ADDR_BITS-1:0] ptr,
  output logic [2:0]           ai_mode,
  output logic                 busy,
  output logic                 err
);
  typedef enum logic [2:0] {
    IDLE, GET_CTRL, WR_DATA, WR_COMMIT, RD_IDLE, RD_FETCH, RD_PRESENT
  } state_e;

  localparam logic [ADDR_BITS-1:0] LAST_REG = ADDR_BITS'(NUM_REGS - 1);

  state_e               state_q, state_d, tgt;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d, addr_q, addr_d;
  logic [2:0]           ai_q, ai_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d, rbyte_q, rbyte_d;
  logic                 err_q, err_d;
  logic                 pend_q, pend_d, pend_go_q, pend_go_d, pend_rw_q, pend_rw_d;
  logic                 ev_now, done_ev, done_go, done_rw, addr_ok, err_set;
  logic                 in_wr, in_rd, w_en, r_en;

  function automatic logic [ADDR_BITS-1:0] advance(input logic [ADDR_BITS-1:0] p,
                                                   input logic [2:0] ai);
    logic [ADDR_BITS-1:0] lo, hi;
    case (ai[1:0])
      2'b00:   begin lo = '0;            hi = LAST_REG;       end
      2'b01:   begin lo = ADDR_BITS'(2); hi = ADDR_BITS'(5); end
      2'b10:   begin lo = ADDR_BITS'(6); hi = ADDR_BITS'(7); end
      default: begin lo = ADDR_BITS'(2); hi = ADDR_BITS'(7); end
    endcase
    if (!ai[2])            advance = p;
    else if (p == hi)      advance = lo;
    else if (p >= LAST_REG) advance = '0;
    else                   advance = p + ADDR_BITS'(1);
  endfunction

  // A START/STOP seen while a byte is in flight is replayed once that byte completes.
  assign ev_now  = xfer_start | xfer_stop;
  assign done_ev = ev_now | pend_q;
  assign done_go = ev_now ? xfer_start : pend_go_q;
  assign done_rw = ev_now ? xfer_rw : pend_rw_q;
  assign tgt     = !done_go ? IDLE : (done_rw ? RD_IDLE : GET_CTRL);
  assign addr_ok = addr_q <= LAST_REG;
  assign in_wr   = state_q inside {GET_CTRL, WR_DATA, WR_COMMIT};
  assign in_rd   = state_q inside {RD_IDLE, RD_FETCH, RD_PRESENT};
  assign err_set = (wr_valid && in_rd)
                || (rd_req && (in_wr || state_q inside {RD_FETCH, RD_PRESENT}))
                || (state_q inside {WR_COMMIT, RD_FETCH} && !addr_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      ai_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rbyte_q   <= '0;
      err_q     <= 1'b0;
      pend_q    <= 1'b0;
      pend_go_q <= 1'b0;
      pend_rw_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      ai_q      <= ai_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rbyte_q   <= rbyte_d;
      err_q     <= err_d;
      pend_q    <= pend_d;
      pend_go_q <= pend_go_d;
      pend_rw_q <= pend_rw_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    pend_go_d = pend_go_q;
    pend_rw_d = pend_rw_q;
    case (state_q)
      IDLE:       if (xfer_start) state_d = xfer_rw ? RD_IDLE : GET_CTRL;
      GET_CTRL:   if (ev_now) state_d = tgt; else if (wr_valid) state_d = WR_DATA;
      WR_DATA:    if (wr_valid) state_d = WR_COMMIT; else if (ev_now) state_d = tgt;
      WR_COMMIT:  state_d = done_ev ? tgt : WR_DATA;
      RD_IDLE:    if (rd_req) state_d = RD_FETCH; else if (ev_now) state_d = tgt;
      RD_FETCH:   state_d = RD_PRESENT;
      RD_PRESENT: state_d = done_ev ? tgt : RD_IDLE;
      default:    state_d = IDLE;
    endcase
    if (ev_now) begin
      pend_d    = 1'b1;
      pend_go_d = xfer_start;
      pend_rw_d = xfer_rw;
    end
    if (!(state_d inside {WR_COMMIT, RD_FETCH, RD_PRESENT})) pend_d = 1'b0;
  end

  always_comb begin
    ptr_d   = ptr_q;
    ai_d    = ai_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rbyte_d = rbyte_q;
    err_d   = err_q;
    case (state_q)
      GET_CTRL: if (wr_valid) begin
        ptr_d = wr_byte[ADDR_BITS-1:0];
        ai_d  = wr_byte[DATA_BITS-1 -: 3];
      end
      WR_DATA: if (wr_valid) begin
        addr_d  = ptr_q;
        wdata_d = wr_byte;
      end
      WR_COMMIT:  ptr_d = advance(ptr_q, ai_q);
      RD_IDLE:    if (rd_req) addr_d = ptr_q;
      RD_FETCH:   rbyte_d = addr_ok ? bus.bus_rdata : '0;
      RD_PRESENT: ptr_d = advance(ptr_q, ai_q);
      default: ;
    endcase
    if (err_set)    err_d = 1'b1;
    if (xfer_start) err_d = 1'b0;
  end

  always_comb begin
    w_en     = (state_q == WR_COMMIT) && addr_ok;
    r_en     = (state_q == RD_FETCH) && addr_ok;
    rd_valid = state_q == RD_PRESENT;
    busy     = state_q != IDLE;
  end

  assign bus.bus_w_en  = w_en;
  assign bus.bus_r_en  = r_en;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign rd_byte       = rbyte_q;
  assign ptr           = ptr_q;
  assign ai_mode       = ai_q;
  assign err           = err_q;
endmodule
